// File: rtl/acq_scheduler_if.sv
// Frame-level handshake between acq_scheduler, the sensor driver and the AXIS packetizer.
// master: the scheduler (drives frame_*, observes the sensor stream and packetizer busy).
// slave:  the datapath side (drives sensor stream and pkt_busy, observes frame_*).
interface acq_scheduler_if;
  logic        sensor_valid;
  logic [9:0]  sensor_index;
  logic        pkt_busy;
  logic        frame_trigger;
  logic        frame_active;
  logic        frame_send_raw;
  logic        frame_last;
  logic [15:0] frame_id;

  modport master (
    input  sensor_valid, sensor_index, pkt_busy,
    output frame_trigger, frame_active, frame_send_raw, frame_last, frame_id
  );

  modport slave (
    output sensor_valid, sensor_index, pkt_busy,
    input  frame_trigger, frame_active, frame_send_raw, frame_last, frame_id
  );
endinterface

// File: rtl/acq_scheduler.sv
// Frame scheduler for the S15611 acquisition chain: periodic frame triggers, frame
// completion tracking, per-frame mode/last latching and packetizer back-pressure.
// Optional capture watchdog: define ACQ_SCHED_TIMEOUT_EN to compile it in; otherwise
// err_timeout is tied low and a capture waits indefinitely for the last pixel.
module acq_scheduler #(
  parameter int unsigned FRAME_PIXELS   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic          master_clock,
  input  logic          resetn,
  input  logic          cfg_start,
  input  logic          cfg_stop,
  input  logic          cfg_continuous,
  input  logic [15:0]   cfg_num_frames,
  input  logic [31:0]   cfg_frame_period,
  input  logic          cfg_send_raw,
  acq_scheduler_if.master bus,
  output logic          run_busy,
  output logic          run_done,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam logic [9:0] LastIndex = 10'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    StIdle, StTrigger, StCapture, StDrain, StWaitPeriod, StDone
  } state_e;

  state_e state_q, state_d;

  logic        cont_q, cont_d;
  logic [15:0] num_q, num_d;
  logic [31:0] period_q, period_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic        stop_q, stop_d;
  logic [15:0] frame_id_q, frame_id_d;
  logic        send_raw_q, send_raw_d;
  logic        last_q, last_d;
  logic        trigger_q, trigger_d;
  logic        active_q, active_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;
  logic        err_timeout_q;
  logic        timeout_hit;
  logic        frame_done;

  assign frame_done = bus.sensor_valid && (bus.sensor_index == LastIndex);

`ifdef ACQ_SCHED_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_timeout_d;

  // Counts clocks since the trigger; fires on the last allowed capture cycle.
  assign timeout_hit = (state_q == StCapture) && (wdog_q >= WdogW'(TIMEOUT_CYCLES - 1));

  // Watchdog and sticky timeout flag next-state.
  always_comb begin
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;
    if (state_d == StTrigger) begin
      wdog_d = '0;
    end else if ((state_q == StTrigger || state_q == StCapture) && (wdog_q != '1)) begin
      wdog_d = wdog_q + 1'b1;
    end
    if (state_q == StIdle && cfg_start) begin
      err_timeout_d = 1'b0;
    end else if (timeout_hit && !frame_done) begin
      err_timeout_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign err_timeout_q = 1'b0;
`endif

  // State register.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (cfg_start) state_d = StTrigger;
      StTrigger:    state_d = StCapture;
      StCapture:    if (frame_done || timeout_hit) state_d = StDrain;
      StDrain: begin
        if (!bus.pkt_busy) begin
          if (err_timeout_q || stop_q || (!cont_q && (frame_id_q >= num_q))) state_d = StDone;
          else                                                             state_d = StWaitPeriod;
        end
      end
      StWaitPeriod: if (period_cnt_q >= period_q - 32'd1) state_d = StTrigger;
      StDone:       state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // Output and run-context next values; the _d of the latched config is used on the
  // first trigger because it is captured on the same edge.
  always_comb begin
    cont_d       = cont_q;
    num_d        = num_q;
    period_d     = period_q;
    stop_d       = stop_q;
    frame_id_d   = frame_id_q;
    send_raw_d   = send_raw_q;
    last_d       = last_q;
    overrun_d    = overrun_q;
    period_cnt_d = period_cnt_q;

    if (state_q == StIdle) begin
      if (cfg_start) begin
        cont_d     = cfg_continuous;
        num_d      = (cfg_num_frames == 16'd0) ? 16'd1 : cfg_num_frames;
        period_d   = (cfg_frame_period < 32'd2) ? 32'd2 : cfg_frame_period;
        frame_id_d = '0;
        overrun_d  = 1'b0;
        stop_d     = cfg_stop;
      end
    end else if (cfg_stop) begin
      stop_d = 1'b1;
    end

    if (state_q == StCapture && frame_done) frame_id_d = frame_id_q + 16'd1;

    // Leaving CAPTURE+DRAIN already past the period means the trigger is late.
    if (state_q == StWaitPeriod && period_cnt_q >= period_q) overrun_d = 1'b1;

    if (state_d == StTrigger) begin
      send_raw_d = cfg_send_raw;
      last_d     = !cont_d && (frame_id_d == num_d - 16'd1);
    end else if (state_d == StDone) begin
      last_d = 1'b0;
    end

    if (state_d == StTrigger) begin
      period_cnt_d = '0;
    end else if (state_q != StIdle && period_cnt_q != '1) begin
      period_cnt_d = period_cnt_q + 32'd1;
    end

    trigger_d = (state_d == StTrigger);
    active_d  = (state_d == StTrigger) || (state_d == StCapture);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
  end

  // Registered outputs and run context.
  always_ff @(posedge master_clock or negedge resetn) begin
    if (!resetn) begin
      cont_q       <= 1'b0;
      num_q        <= '0;
      period_q     <= '0;
      period_cnt_q <= '0;
      stop_q       <= 1'b0;
      frame_id_q   <= '0;
      send_raw_q   <= 1'b0;
      last_q       <= 1'b0;
      trigger_q    <= 1'b0;
      active_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cont_q       <= cont_d;
      num_q        <= num_d;
      period_q     <= period_d;
      period_cnt_q <= period_cnt_d;
      stop_q       <= stop_d;
      frame_id_q   <= frame_id_d;
      send_raw_q   <= send_raw_d;
      last_q       <= last_d;
      trigger_q    <= trigger_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.frame_trigger  = trigger_q;
  assign bus.frame_active   = active_q;
  assign bus.frame_send_raw = send_raw_q;
  assign bus.frame_last     = last_q;
  assign bus.frame_id       = frame_id_q;
  assign run_busy           = busy_q;
  assign run_done           = done_q;
  assign err_timeout        = err_timeout_q;
  assign err_overrun        = overrun_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench for acq_scheduler with a small sensor-driver model and trigger monitor.
module tb_acq_scheduler;
  localparam int unsigned FP = 256;
  localparam int unsigned TO = 500;

  logic        master_clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        cfg_continuous = 1'b0;
  logic [15:0] cfg_num_frames = '0;
  logic [31:0] cfg_frame_period = '0;
  logic        cfg_send_raw = 1'b0;
  logic        run_busy, run_done, err_timeout, err_overrun;

  acq_scheduler_if bus ();

  acq_scheduler #(.FRAME_PIXELS(FP), .TIMEOUT_CYCLES(TO)) dut (
    .master_clock     (master_clock),
    .resetn           (resetn),
    .cfg_start        (cfg_start),
    .cfg_stop         (cfg_stop),
    .cfg_continuous   (cfg_continuous),
    .cfg_num_frames   (cfg_num_frames),
    .cfg_frame_period (cfg_frame_period),
    .cfg_send_raw     (cfg_send_raw),
    .bus              (bus),
    .run_busy         (run_busy),
    .run_done         (run_done),
    .err_timeout      (err_timeout),
    .err_overrun      (err_overrun)
  );

  always #5 master_clock = ~master_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle counter and trigger/done monitor, sampled on the falling edge.
  int   cyc = 0;
  int   trig_n = 0;
  int   done_n = 0;
  int   trig_t [64];
  logic last_at [64];
  logic raw_at [64];

  initial forever begin
    @(posedge master_clock);
    cyc++;
  end

  initial forever begin
    @(negedge master_clock);
    if (bus.frame_trigger === 1'b1) begin
      if (trig_n < 64) begin
        trig_t[trig_n]  = cyc;
        last_at[trig_n] = bus.frame_last;
        raw_at[trig_n]  = bus.frame_send_raw;
      end
      trig_n++;
    end
    if (run_done === 1'b1) done_n++;
  end

  // Sensor driver model: streams FP pixels drv_delay clocks after each trigger.
  logic drv_en = 1'b1;
  int   drv_delay = 5;
  int   kick_req = 0;

  task automatic stream_frame();
    repeat (drv_delay) @(negedge master_clock);
    for (int i = 0; i < FP; i++) begin
      bus.sensor_valid = 1'b1;
      bus.sensor_index = 10'(i);
      @(negedge master_clock);
    end
    bus.sensor_valid = 1'b0;
    bus.sensor_index = '0;
  endtask

  initial begin
    int kick_ack;
    kick_ack = 0;
    bus.sensor_valid = 1'b0;
    bus.sensor_index = '0;
    forever begin
      @(negedge master_clock);
      if ((drv_en && bus.frame_trigger === 1'b1) || kick_req != kick_ack) begin
        kick_ack = kick_req;
        stream_frame();
      end
    end
  end

  task automatic set_cfg(input logic cont, input logic [15:0] num, input logic [31:0] per);
    cfg_continuous   = cont;
    cfg_num_frames   = num;
    cfg_frame_period = per;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge master_clock);
    cfg_start = 1'b0;
  endtask

  task automatic wait_trig(input int n, input int budget);
    for (int k = 0; k < budget && trig_n < n; k++) @(negedge master_clock);
    if (trig_n < n) check_eq("wait_trigger", trig_n, n);
  endtask

  task automatic wait_done(input int prev, input int budget);
    for (int k = 0; k < budget && done_n <= prev; k++) @(negedge master_clock);
    if (done_n <= prev) check_eq("wait_run_done", done_n, prev + 1);
    repeat (3) @(negedge master_clock);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1);
  end

  initial begin
    int b, d, s, t0, dcyc, k;
    bus.pkt_busy = 1'b0;

    // Reset values
    repeat (3) @(negedge master_clock);
    check_eq("rst_trigger", bus.frame_trigger, 0);
    check_eq("rst_busy", run_busy, 0);
    check_eq("rst_frame_id", bus.frame_id, 0);
    resetn = 1'b1;
    repeat (3) @(negedge master_clock);

    // Three frames, non-continuous
    set_cfg(1'b0, 16'd3, 32'd1000);
    b = trig_n; d = done_n; s = cyc;
    pulse_start();
    check_eq("t1_trigger_pulse", bus.frame_trigger, 1);
    check_eq("t1_busy_at_trigger", run_busy, 1);
    @(negedge master_clock);
    check_eq("t1_trigger_one_cycle", bus.frame_trigger, 0);
    check_eq("t1_active", bus.frame_active, 1);
    wait_done(d, 6000);
    check_eq("t1_triggers", trig_n - b, 3);
    check_eq("t1_first_latency", trig_t[b] - s, 1);
    check_eq("t1_spacing_1", trig_t[b+1] - trig_t[b], 1000);
    check_eq("t1_spacing_2", trig_t[b+2] - trig_t[b+1], 1000);
    check_eq("t1_last_f1", last_at[b], 0);
    check_eq("t1_last_f3", last_at[b+2], 1);
    check_eq("t1_frame_id", bus.frame_id, 3);
    check_eq("t1_done_once", done_n - d, 1);
    check_eq("t1_idle", run_busy, 0);
    check_eq("t1_last_cleared", bus.frame_last, 0);
    check_eq("t1_no_overrun", err_overrun, 0);

    // Continuous run stopped mid frame 2
    set_cfg(1'b1, 16'd1, 32'd1000);
    b = trig_n; d = done_n;
    pulse_start();
    wait_trig(b + 2, 3000);
    repeat (100) @(negedge master_clock);
    cfg_stop = 1'b1;
    @(negedge master_clock);
    cfg_stop = 1'b0;
    wait_done(d, 3000);
    repeat (1500) @(negedge master_clock);
    check_eq("t2_triggers", trig_n - b, 2);
    check_eq("t2_frame_id", bus.frame_id, 2);
    check_eq("t2_done_once", done_n - d, 1);
    check_eq("t2_last_cont", last_at[b+1], 0);

    // Period shorter than capture -> overrun, trigger right after drain
    set_cfg(1'b0, 16'd2, 32'd100);
    b = trig_n; d = done_n;
    pulse_start();
    wait_done(d, 3000);
    check_eq("t3_spacing", trig_t[b+1] - trig_t[b], 263);
    check_eq("t3_overrun", err_overrun, 1);
    check_eq("t3_frame_id", bus.frame_id, 2);

    // Silent driver
    drv_en = 1'b0;
    set_cfg(1'b0, 16'd1, 32'd1000);
    d = done_n;
    pulse_start();
    t0 = cyc;
`ifdef ACQ_SCHED_TIMEOUT_EN
    k = 0;
    while (err_timeout !== 1'b1 && k < 2000) begin
      @(negedge master_clock);
      k++;
    end
    check_eq("t4_timeout_at", cyc - t0, 500);
    wait_done(d, 2000);
    check_eq("t4_done", done_n - d, 1);
    check_eq("t4_frame_id", bus.frame_id, 0);
    check_eq("t4_err_sticky", err_timeout, 1);
`else
    repeat (600) @(negedge master_clock);
    check_eq("t4_no_timeout", err_timeout, 0);
    check_eq("t4_still_active", bus.frame_active, 1);
    kick_req++;
    wait_done(d, 2000);
    check_eq("t4_frame_id", bus.frame_id, 1);
`endif
    drv_en = 1'b1;
    repeat (10) @(negedge master_clock);

    // Packetizer busy past the period
    set_cfg(1'b0, 16'd2, 32'd1000);
    b = trig_n; d = done_n;
    pulse_start();
    check_eq("t5_err_timeout_cleared", err_timeout, 0);
    check_eq("t5_overrun_cleared", err_overrun, 0);
    bus.pkt_busy = 1'b1;
    repeat (2000) @(negedge master_clock);
    check_eq("t5_held_off", trig_n - b, 1);
    dcyc = cyc;
    bus.pkt_busy = 1'b0;
    wait_done(d, 3000);
    check_eq("t5_trigger_after_busy", trig_t[b+1] - dcyc, 2);
    check_eq("t5_overrun", err_overrun, 1);
    check_eq("t5_frame_id", bus.frame_id, 2);

    // Per-frame raw mode, then reset mid capture
    set_cfg(1'b0, 16'd3, 32'd1000);
    cfg_send_raw = 1'b1;
    b = trig_n;
    pulse_start();
    cfg_send_raw = 1'b0;
    wait_trig(b + 2, 2000);
    cfg_send_raw = 1'b1;
    wait_trig(b + 3, 2000);
    repeat (50) @(negedge master_clock);
    check_eq("t6_raw_f1", raw_at[b], 1);
    check_eq("t6_raw_f2", raw_at[b+1], 0);
    check_eq("t6_raw_f3", raw_at[b+2], 1);
    check_eq("t6_frame_id_pre", bus.frame_id, 2);
    check_eq("t6_last_pre", bus.frame_last, 1);
    check_eq("t6_active_pre", bus.frame_active, 1);
    d = done_n;
    #2 resetn = 1'b0;
    #1;
    check_eq("t6_rst_active", bus.frame_active, 0);
    check_eq("t6_rst_busy", run_busy, 0);
    check_eq("t6_rst_frame_id", bus.frame_id, 0);
    check_eq("t6_rst_raw", bus.frame_send_raw, 0);
    check_eq("t6_rst_last", bus.frame_last, 0);
    check_eq("t6_rst_overrun", err_overrun, 0);
    repeat (3) @(negedge master_clock);
    resetn = 1'b1;
    repeat (300) @(negedge master_clock);
    check_eq("t6_no_done", done_n - d, 0);
    check_eq("t6_idle_after", run_busy, 0);

    // Start and stop together -> exactly one frame
    set_cfg(1'b0, 16'd5, 32'd1000);
    b = trig_n; d = done_n;
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    @(negedge master_clock);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    wait_done(d, 2000);
    repeat (1200) @(negedge master_clock);
    check_eq("t7_triggers", trig_n - b, 1);
    check_eq("t7_frame_id", bus.frame_id, 1);

    // num_frames = 0 behaves as one frame
    set_cfg(1'b0, 16'd0, 32'd0);
    b = trig_n; d = done_n;
    pulse_start();
    wait_done(d, 2000);
    check_eq("t8_triggers", trig_n - b, 1);
    check_eq("t8_last", last_at[b], 1);
    check_eq("t8_frame_id", bus.frame_id, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/acq_scheduler.md
# acq_scheduler

Frame-level controller for the S15611 acquisition chain. Issues a one-cycle `frame_trigger` to the sensor driver at a programmed period, tracks frame completion from the driver's `data_valid`/`data_index` stream, latches per-frame mode (raw or processed) and the last-frame marker for the AXIS packetizer, and holds off new frames while the packetizer is busy. Sits between the PS configuration registers and the `sensor_data_acquisition` datapath, all on `master_clock`.

## Interface
- `FRAME_PIXELS`, 1024: pixels per frame; a frame completes on index `FRAME_PIXELS-1`.
- `TIMEOUT_CYCLES`, 200000: capture watchdog limit, in clocks.
- `master_clock`  in  1  40 MHz system clock; only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  start a run (sampled level; ignored while `run_busy`).
- `cfg_stop`  in  1  request stop at the next frame boundary.
- `cfg_continuous`  in  1  1 = run until stopped; sampled at start.
- `cfg_num_frames`  in  16  frames per run; 0 treated as 1; sampled at start.
- `cfg_frame_period`  in  32  clocks between triggers; values <2 treated as 2; sampled at start.
- `cfg_send_raw`  in  1  mode, latched into `frame_send_raw` at every trigger.
- `sensor_valid`  in  1  driver `data_valid`.
- `sensor_index`  in  10  driver `data_index`.
- `pkt_busy`  in  1  packetizer still emitting the previous frame.
- `frame_trigger`  out  1  one-cycle start-of-integration pulse.
- `frame_active`  out  1  high from trigger until frame complete/abort.
- `frame_send_raw`  out  1  mode of current frame.
- `frame_last`  out  1  current frame is last of run (packetizer sets `tlast`).
- `frame_id`  out  16  frames completed this run (wraps at 65535→0).
- `run_busy`  out  1  state ≠ IDLE.
- `run_done`  out  1  one-cycle pulse at end of run.
- `err_timeout`  out  1  sticky; cleared at next `cfg_start`.
- `err_overrun`  out  1  sticky; cleared at next `cfg_start`.

## Operation
- States: IDLE, TRIGGER, CAPTURE, DRAIN, WAIT_PERIOD, DONE.
- IDLE: on `cfg_start`=1 latch `cfg_*`, clear `frame_id`, errors, stop request → TRIGGER.
- TRIGGER (1 cycle): `frame_trigger`=1, clear `period_cnt` and watchdog, latch `frame_send_raw`, set `frame_last` = !continuous && (`frame_id` == num_frames-1) → CAPTURE.
- CAPTURE: complete when `sensor_valid`=1 && `sensor_index`==`FRAME_PIXELS-1` → `frame_id`+1, DRAIN. Watchdog reaching `TIMEOUT_CYCLES` → set `err_timeout`, DRAIN without incrementing `frame_id`.
- DRAIN: wait `pkt_busy`=0. Then: stop request, or !continuous && `frame_id` ≥ num_frames → DONE; else WAIT_PERIOD. `err_timeout` set this frame → DONE.
- WAIT_PERIOD: when `period_cnt` ≥ period-1 → TRIGGER. If already ≥ period on entry, set `err_overrun` and go TRIGGER next cycle.
- DONE (1 cycle): `run_done`=1 → IDLE.
- `period_cnt` 32-bit, increments every cycle outside IDLE, saturates at 2^32-1.
- `cfg_stop` latched sticky whenever `run_busy`; ignored in IDLE. Stop in CAPTURE finishes the current frame.
- `cfg_start` and `cfg_stop` both high in IDLE: run starts, stop latched, exactly one frame captured.

## Timing
- All outputs registered; reset values: all 0, state IDLE.
- `cfg_start` sampled at edge N → `frame_trigger` high N+1..N+2 only, `run_busy` high from N+1.
- Steady state with capture+drain < period: trigger-to-trigger spacing exactly `cfg_frame_period` clocks.
- `frame_active` falls the cycle after the completing index is sampled.
- `frame_last` stable throughout frame; cleared at DONE.
- Reset assertion mid-run: immediate return to IDLE, outputs to reset values, no `run_done`.

## Configuration
- `ACQ_SCHED_TIMEOUT_EN` defined: watchdog compiled in as above.
- Undefined: no watchdog counter; `err_timeout` tied 0; CAPTURE waits indefinitely for frame completion.

## Test plan
- num_frames=3, period=50000, continuous=0, driver model 1024 pixels, pkt_busy=0 → 3 triggers 50000 clocks apart, `frame_last` on 3rd, `run_done` once, `frame_id`=3.
- continuous=1, `cfg_stop` pulsed mid-frame 2 → frame 2 completes, no 3rd trigger, `run_done`, `frame_id`=2.
- period=100, capture takes 2000 clocks → `err_overrun`=1, next trigger 1 clock after DRAIN exit.
- Driver silent after trigger (macro defined, TIMEOUT_CYCLES=500) → `err_timeout`=1 at 500 clocks, `run_done`, `frame_id`=0.
- `pkt_busy` held 10000 clocks after frame 1, period=5000 → no trigger until busy drops, then `err_overrun`.
- Toggle `cfg_send_raw` between frames; assert `resetn`=0 mid-CAPTURE → `frame_send_raw` tracks per-frame value; reset zeroes all outputs asynchronously.
